alu_ctrl_fsm: RTL and testbench

//  Multi-cycle control unit that issues work to the ALU: fetches and decodes MIPS-subset instructions and

---
 rtl/alu_ctrl_fsm_pkg.sv | 71 +++++++
 rtl/alu_ctrl_decode.sv | 52 +++++
 rtl/alu_ctrl_fsm.sv | 212 +++++++++++++++++++++
 tb/tb_alu_ctrl_fsm.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/alu_ctrl_fsm_pkg.sv
// Shared encodings for the multi-cycle ALU control unit: ALU operation
// codes, opcode/funct values, FSM states, PC source codes, decode classes.
package alu_ctrl_fsm_pkg;

  // ALU operation select (10-15 are never driven)
  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_AND = 4'd2;
  localparam logic [3:0] ALU_OR  = 4'd3;
  localparam logic [3:0] ALU_XOR = 4'd4;
  localparam logic [3:0] ALU_NOR = 4'd5;
  localparam logic [3:0] ALU_SLT = 4'd6;
  localparam logic [3:0] ALU_SLL = 4'd7;
  localparam logic [3:0] ALU_SRL = 4'd8;
  localparam logic [3:0] ALU_LUI = 4'd9;

  // Primary opcodes IR[31:26]
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // R-type funct IR[5:0]
  localparam logic [5:0] FN_SLL = 6'h00;
  localparam logic [5:0] FN_SRL = 6'h02;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_XOR = 6'h26;
  localparam logic [5:0] FN_NOR = 6'h27;
  localparam logic [5:0] FN_SLT = 6'h2A;

  // PC source select
  localparam logic [1:0] PC_SEQ    = 2'b00;
  localparam logic [1:0] PC_BRANCH = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;
  localparam logic [1:0] PC_EXC    = 2'b11;

  typedef enum logic [2:0] {
    ST_IF  = 3'd0,
    ST_ID  = 3'd1,
    ST_EX  = 3'd2,
    ST_MEM = 3'd3,
    ST_WB  = 3'd4,
    ST_EXC = 3'd5
  } state_t;

  // Instruction class steers the FSM after EX
  typedef enum logic [2:0] {
    CL_ALU = 3'd0,
    CL_LW  = 3'd1,
    CL_SW  = 3'd2,
    CL_BEQ = 3'd3,
    CL_J   = 3'd4
  } iclass_t;

  // Pending exception cause, consumed in EXC
  typedef enum logic [1:0] {
    EXC_NONE = 2'd0,
    EXC_OVF  = 2'd1,
    EXC_ILL  = 2'd2,
    EXC_BUS  = 2'd3
  } exc_t;

endpackage

// File: rtl/alu_ctrl_decode.sv
// Combinational instruction decode: opcode/funct -> ALU select, operand B
// source, destination select, instruction class, overflow-trap and illegal.
module alu_ctrl_decode
  import alu_ctrl_fsm_pkg::*;
(
  input  logic [5:0] op,
  input  logic [5:0] funct,
  output logic [3:0] sel_alu,
  output logic       alu_src_imm,
  output logic       wr_rd,
  output logic       trap_ovf,
  output logic [2:0] iclass,
  output logic       illegal
);

  // Decode table; anything not listed is illegal
  always_comb begin
    sel_alu     = ALU_ADD;
    alu_src_imm = 1'b0;
    wr_rd       = 1'b0;
    trap_ovf    = 1'b0;
    iclass      = CL_ALU;
    illegal     = 1'b0;
    case (op)
      OP_RTYPE: begin
        wr_rd = 1'b1;
        case (funct)
          FN_ADD: begin sel_alu = ALU_ADD; trap_ovf = 1'b1; end
          FN_SUB: begin sel_alu = ALU_SUB; trap_ovf = 1'b1; end
          FN_AND: sel_alu = ALU_AND;
          FN_OR:  sel_alu = ALU_OR;
          FN_XOR: sel_alu = ALU_XOR;
          FN_NOR: sel_alu = ALU_NOR;
          FN_SLT: sel_alu = ALU_SLT;
          FN_SLL: sel_alu = ALU_SLL;
          FN_SRL: sel_alu = ALU_SRL;
          default: illegal = 1'b1;
        endcase
      end
      OP_ADDI: begin sel_alu = ALU_ADD; alu_src_imm = 1'b1; trap_ovf = 1'b1; end
      OP_ANDI: begin sel_alu = ALU_AND; alu_src_imm = 1'b1; end
      OP_ORI:  begin sel_alu = ALU_OR;  alu_src_imm = 1'b1; end
      OP_LUI:  begin sel_alu = ALU_LUI; alu_src_imm = 1'b1; end
      OP_LW:   begin sel_alu = ALU_ADD; alu_src_imm = 1'b1; iclass = CL_LW; end
      OP_SW:   begin sel_alu = ALU_ADD; alu_src_imm = 1'b1; iclass = CL_SW; end
      OP_BEQ:  begin sel_alu = ALU_SUB; iclass = CL_BEQ; end
      OP_J:    iclass = CL_J;
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_ctrl_fsm.sv
// Multi-cycle control unit: IF -> ID -> EX -> {MEM} -> {WB} -> IF, with an
// EXC state for overflow, illegal-instruction and memory-watchdog traps.
// Holds the FSM, instruction register, watchdog and optional retire counter.
// Optional feature macro: ALU_CTRL_STATS_EN (retired-instruction counter).
// TIMEOUT must be less than 2**TIMEOUT_W.
module alu_ctrl_fsm
  import alu_ctrl_fsm_pkg::*;
#(
  parameter int TIMEOUT_W = 8,
  parameter int TIMEOUT   = 200
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instr,
  input  logic        instr_valid,
  input  logic        dmem_ready,
  input  logic        flag_beq,
  input  logic        flag_add_overflow,
  output logic        imem_req,
  output logic [3:0]  sel_alu,
  output logic [15:0] imm16,
  output logic        alu_src_imm,
  output logic [4:0]  rs_addr,
  output logic [4:0]  rt_addr,
  output logic [4:0]  wr_addr,
  output logic        reg_we,
  output logic        mem_to_reg,
  output logic        dmem_re,
  output logic        dmem_we,
  output logic        pc_we,
  output logic [1:0]  pc_src,
  output logic [25:0] jump_target,
  output logic        exc_overflow,
  output logic        exc_illegal,
  output logic        exc_bus,
  output logic [31:0] retired_cnt
);

  state_t               state, state_nx;
  exc_t                 exc_q, exc_nx;
  logic [31:0]          ir;
  logic                 ir_ld;
  logic [TIMEOUT_W-1:0] wd, wd_nx;
  logic                 wd_hit;
  // Low for the first cycle after reset release so no output (notably
  // imem_req) is asserted while still coming out of reset.
  logic                 run_q;

  logic [3:0] dec_sel;
  logic       dec_src, dec_wr_rd, dec_trap, dec_ill;
  logic [2:0] dec_cls;
  iclass_t    cls;

  alu_ctrl_decode u_dec (
    .op          (ir[31:26]),
    .funct       (ir[5:0]),
    .sel_alu     (dec_sel),
    .alu_src_imm (dec_src),
    .wr_rd       (dec_wr_rd),
    .trap_ovf    (dec_trap),
    .iclass      (dec_cls),
    .illegal     (dec_ill)
  );

  assign cls         = iclass_t'(dec_cls);
  assign imm16       = ir[15:0];
  assign rs_addr     = ir[25:21];
  assign rt_addr     = ir[20:16];
  assign jump_target = ir[25:0];
  assign wr_addr     = dec_wr_rd ? ir[15:11] : ir[20:16];
  assign wd_hit      = (wd == TIMEOUT_W'(TIMEOUT - 1));

  // State, IR, watchdog and pending exception cause
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IF;
      exc_q <= EXC_NONE;
      ir    <= '0;
      wd    <= '0;
      run_q <= 1'b0;
    end else begin
      state <= state_nx;
      exc_q <= exc_nx;
      wd    <= wd_nx;
      run_q <= 1'b1;
      if (ir_ld) ir <= instr;
    end
  end

  // Next state and control outputs from registered state + IR
  always_comb begin
    state_nx     = state;
    exc_nx       = exc_q;
    wd_nx        = wd;
    ir_ld        = 1'b0;
    imem_req     = 1'b0;
    sel_alu      = ALU_ADD;
    alu_src_imm  = 1'b0;
    reg_we       = 1'b0;
    mem_to_reg   = 1'b0;
    dmem_re      = 1'b0;
    dmem_we      = 1'b0;
    pc_we        = 1'b0;
    pc_src       = PC_SEQ;
    exc_overflow = 1'b0;
    exc_illegal  = 1'b0;
    exc_bus      = 1'b0;
    case (state)
      ST_IF: begin
        if (run_q) begin
          imem_req = 1'b1;
          if (instr_valid) begin
            ir_ld    = 1'b1;
            pc_we    = 1'b1;
            pc_src   = PC_SEQ;
            state_nx = ST_ID;
          end else if (wd_hit) begin
            state_nx = ST_EXC;
            exc_nx   = EXC_BUS;
          end else begin
            wd_nx = wd + TIMEOUT_W'(1);
          end
        end
      end
      ST_ID: begin
        if (dec_ill) begin
          state_nx = ST_EXC;
          exc_nx   = EXC_ILL;
        end else if (cls == CL_J) begin
          pc_we    = 1'b1;
          pc_src   = PC_JUMP;
          state_nx = ST_IF;
        end else begin
          state_nx = ST_EX;
        end
      end
      ST_EX: begin
        sel_alu     = dec_sel;
        alu_src_imm = dec_src;
        case (cls)
          CL_BEQ: begin
            if (flag_beq) begin
              pc_we  = 1'b1;
              pc_src = PC_BRANCH;
            end
            state_nx = ST_IF;
          end
          CL_LW, CL_SW: state_nx = ST_MEM;
          default: begin
            if (dec_trap && flag_add_overflow) begin
              state_nx = ST_EXC;
              exc_nx   = EXC_OVF;
            end else begin
              state_nx = ST_WB;
            end
          end
        endcase
      end
      ST_MEM: begin
        dmem_re = (cls == CL_LW);
        dmem_we = (cls == CL_SW);
        if (dmem_ready) begin
          state_nx = (cls == CL_LW) ? ST_WB : ST_IF;
        end else if (wd_hit) begin
          state_nx = ST_EXC;
          exc_nx   = EXC_BUS;
        end else begin
          wd_nx = wd + TIMEOUT_W'(1);
        end
      end
      ST_WB: begin
        reg_we     = 1'b1;
        mem_to_reg = (cls == CL_LW);
        state_nx   = ST_IF;
      end
      ST_EXC: begin
        exc_overflow = (exc_q == EXC_OVF);
        exc_illegal  = (exc_q == EXC_ILL);
        exc_bus      = (exc_q == EXC_BUS);
        pc_we        = 1'b1;
        pc_src       = PC_EXC;
        exc_nx       = EXC_NONE;
        state_nx     = ST_IF;
      end
      default: state_nx = ST_IF;
    endcase
    // Any state change restarts the watchdog
    if (state_nx != state) wd_nx = '0;
  end

`ifdef ALU_CTRL_STATS_EN
  logic        retire;
  logic [31:0] ret_q;

  // One completion per instruction; trapped instructions never get here
  assign retire = (state == ST_WB) ||
                  (state == ST_MEM && cls == CL_SW && dmem_ready) ||
                  (state == ST_EX  && cls == CL_BEQ) ||
                  (state == ST_ID  && cls == CL_J && !dec_ill);

  // Wrapping retired-instruction counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      ret_q <= '0;
    else if (retire) ret_q <= ret_q + 32'd1;
  end

  assign retired_cnt = ret_q;
`else
  assign retired_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_alu_ctrl_fsm.sv
module tb_alu_ctrl_fsm;

  logic        clk, rst_n;
  logic [31:0] instr;
  logic        instr_valid, dmem_ready, flag_beq, flag_add_overflow;
  logic        imem_req, alu_src_imm, reg_we, mem_to_reg, dmem_re, dmem_we, pc_we;
  logic [3:0]  sel_alu;
  logic [15:0] imm16;
  logic [4:0]  rs_addr, rt_addr, wr_addr;
  logic [1:0]  pc_src;
  logic [25:0] jump_target;
  logic        exc_overflow, exc_illegal, exc_bus;
  logic [31:0] retired_cnt;

  alu_ctrl_fsm #(.TIMEOUT_W(8), .TIMEOUT(200)) dut (
    .clk(clk), .rst_n(rst_n), .instr(instr), .instr_valid(instr_valid),
    .dmem_ready(dmem_ready), .flag_beq(flag_beq), .flag_add_overflow(flag_add_overflow),
    .imem_req(imem_req), .sel_alu(sel_alu), .imm16(imm16), .alu_src_imm(alu_src_imm),
    .rs_addr(rs_addr), .rt_addr(rt_addr), .wr_addr(wr_addr), .reg_we(reg_we),
    .mem_to_reg(mem_to_reg), .dmem_re(dmem_re), .dmem_we(dmem_we), .pc_we(pc_we),
    .pc_src(pc_src), .jump_target(jump_target), .exc_overflow(exc_overflow),
    .exc_illegal(exc_illegal), .exc_bus(exc_bus), .retired_cnt(retired_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       pc_we;
    logic [1:0] pc_src;
    logic       reg_we;
    logic [4:0] wr_addr;
    logic       m2r;
    logic       ovf;
    logic       ill;
    logic       bus;
  } ev_t;

  ev_t exp_q[$];
  int  n_chk = 0;
  int  n_fail = 0;

  function automatic ev_t mk_ev(logic pw, logic [1:0] ps, logic rw, logic [4:0] wa,
                                logic m2r, logic ov, logic il, logic bu);
    ev_t e;
    e.pc_we = pw; e.pc_src = ps; e.reg_we = rw; e.wr_addr = wa;
    e.m2r = m2r; e.ovf = ov; e.ill = il; e.bus = bu;
    return e;
  endfunction

  function automatic logic [127:0] all_outs();
    return {imem_req, sel_alu, imm16, alu_src_imm, rs_addr, rt_addr, wr_addr, reg_we,
            mem_to_reg, dmem_re, dmem_we, pc_we, pc_src, jump_target,
            exc_overflow, exc_illegal, exc_bus, retired_cnt};
  endfunction

  task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  // Monitor: every strobe/exception cycle must match the next queued event
  always @(negedge clk) begin
    if (rst_n) begin
      ev_t g;
      g = mk_ev(pc_we, pc_src, reg_we, reg_we ? wr_addr : 5'd0, mem_to_reg,
                exc_overflow, exc_illegal, exc_bus);
      if (g.pc_we || g.reg_we || g.ovf || g.ill || g.bus) begin
        n_chk++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_event got=%0h exp=none", g);
        end else begin
          ev_t e;
          e = exp_q.pop_front();
          if (g !== e) begin
            n_fail++;
            $display("FAIL event got=%0h exp=%0h", g, e);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_req(input string nm);
    int i;
    for (i = 0; i < 50 && !imem_req; i++) tick();
    if (!imem_req) begin
      n_chk++; n_fail++;
      $display("FAIL %s_fetch_timeout got=0 exp=1", nm);
    end
  endtask

  // Issue one instruction; queue the fetch event plus an optional later one,
  // check ALU select one cycle after ID and total cycles back to IF.
  task automatic exec(input string nm, input logic [31:0] w, input logic has_ev,
                      input ev_t ev, input logic [3:0] esel, input logic esrc,
                      input int ecyc);
    int c;
    wait_req(nm);
    exp_q.push_back(mk_ev(1'b1, 2'b00, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0));
    if (has_ev) exp_q.push_back(ev);
    instr = w; instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0; instr = 32'hFFFF_FFFF;
    tick();
    c = 2;
    chk({nm, "_sel"}, {123'd0, alu_src_imm, sel_alu}, {123'd0, esrc, esel});
    while (!imem_req && c < 400) begin tick(); c++; end
    chk({nm, "_cycles"}, 128'(c), 128'(ecyc));
  endtask

  initial begin
    ev_t none;
    logic [31:0] exp_ret;
    none = '0;
    rst_n = 1'b0; instr = '0; instr_valid = 1'b0; dmem_ready = 1'b1;
    flag_beq = 1'b0; flag_add_overflow = 1'b0;

    repeat (2) @(negedge clk);
    chk("reset_outputs", all_outs(), 128'd0);
    rst_n = 1'b1;
    #1 chk("imem_req_first_cycle", 128'(imem_req), 128'd0);
    tick();
    chk("imem_req_rise", 128'(imem_req), 128'd1);

    // add $3,$1,$2
    exec("add", 32'h0022_1820, 1'b1, mk_ev(0, 2'b00, 1, 5'd3, 0, 0, 0, 0), 4'd0, 1'b0, 4);
    chk("add_regs", {113'd0, rs_addr, rt_addr, wr_addr}, {113'd0, 5'd1, 5'd2, 5'd3});
    // beq taken / not taken
    flag_beq = 1'b1;
    exec("beq_t", 32'h1022_0004, 1'b1, mk_ev(1, 2'b01, 0, 5'd0, 0, 0, 0, 0), 4'd1, 1'b0, 3);
    flag_beq = 1'b0;
    exec("beq_nt", 32'h1022_0004, 1'b0, none, 4'd1, 1'b0, 3);
    chk("beq_imm16", 128'(imm16), 128'h0004);
    // addi overflow trap
    flag_add_overflow = 1'b1;
    exec("addi_ovf", 32'h2025_0001, 1'b1, mk_ev(1, 2'b11, 0, 5'd0, 0, 1, 0, 0), 4'd0, 1'b1, 4);
    flag_add_overflow = 1'b0;
    // illegal opcode / funct
    exec("ill_op", 32'hFC00_0000, 1'b1, mk_ev(1, 2'b11, 0, 5'd0, 0, 0, 1, 0), 4'd0, 1'b0, 3);
    exec("ill_fn", 32'h0022_183F, 1'b1, mk_ev(1, 2'b11, 0, 5'd0, 0, 0, 1, 0), 4'd0, 1'b0, 3);
    // lw with dmem stalled past the watchdog
    dmem_ready = 1'b0;
    exec("lw_bus", 32'h8C24_0008, 1'b1, mk_ev(1, 2'b11, 0, 5'd0, 0, 0, 0, 1), 4'd0, 1'b1, 204);
    chk("lw_bus_dmem_re_dropped", 128'(dmem_re), 128'd0);
    dmem_ready = 1'b1;
    // zero-wait lw, sll, lui, sw, j
    exec("lw", 32'h8C24_0008, 1'b1, mk_ev(0, 2'b00, 1, 5'd4, 1, 0, 0, 0), 4'd0, 1'b1, 5);
    exec("sll", 32'h0002_1080, 1'b1, mk_ev(0, 2'b00, 1, 5'd2, 0, 0, 0, 0), 4'd7, 1'b0, 4);
    exec("lui", 32'h3C07_1234, 1'b1, mk_ev(0, 2'b00, 1, 5'd7, 0, 0, 0, 0), 4'd9, 1'b1, 4);
    exec("sw", 32'hAC24_000C, 1'b0, none, 4'd0, 1'b1, 4);
    exec("j", 32'h0800_0010, 1'b1, mk_ev(1, 2'b10, 0, 5'd0, 0, 0, 0, 0), 4'd0, 1'b0, 2);
    chk("j_target", 128'(jump_target), 128'h10);

    // Retire count from a clean reset: add, sw, j retire; illegal does not
    #2 rst_n = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    tick();
    exec("s_add", 32'h0022_1820, 1'b1, mk_ev(0, 2'b00, 1, 5'd3, 0, 0, 0, 0), 4'd0, 1'b0, 4);
    exec("s_sw", 32'hAC24_000C, 1'b0, none, 4'd0, 1'b1, 4);
    exec("s_j", 32'h0800_0010, 1'b1, mk_ev(1, 2'b10, 0, 5'd0, 0, 0, 0, 0), 4'd0, 1'b0, 2);
    exec("s_ill", 32'hFC00_0000, 1'b1, mk_ev(1, 2'b11, 0, 5'd0, 0, 0, 1, 0), 4'd0, 1'b0, 3);
`ifdef ALU_CTRL_STATS_EN
    exp_ret = 32'd3;
`else
    exp_ret = 32'd0;
`endif
    chk("retired_cnt", 128'(retired_cnt), 128'(exp_ret));

    // Reset asserted mid-MEM clears every output without a clock edge
    dmem_ready = 1'b0;
    wait_req("mid_rst");
    exp_q.push_back(mk_ev(1'b1, 2'b00, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0));
    instr = 32'h8C24_0008; instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
    tick();
    tick();
    chk("mid_mem_dmem_re", 128'(dmem_re), 128'd1);
    #2 rst_n = 1'b0;
    #1 chk("async_reset_outputs", all_outs(), 128'd0);
    @(negedge clk) rst_n = 1'b1;
    dmem_ready = 1'b1;
    tick();
    chk("after_reset_imem_req", 128'(imem_req), 128'd1);
    chk("queue_drained", 128'(exp_q.size()), 128'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
